// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-client round-robin arbiter sequencing a shared 16-bit ALU
// The ALU is combinational; the arbiter registers operands in IDLE and results in EXEC.
module alu (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  f,
  output logic [15:0] y,
  output logic        z,
  output logic        err
);
  always_comb begin
    y   = 16'h0000;
    err = 1'b0;
    case (f)
      3'b000:  y = b;
      3'b001:  y = a + b;
      3'b010:  y = a - b;
      3'b011:  y = a & b;
      3'b100:  y = a | b;
      3'b101:  y = ~b;
      default: err = 1'b1;
    endcase
  end

  // z is high when the operands differ
  assign z = (a != b);
endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] ri0,
  input  logic [15:0] rj0,
  input  logic [15:0] ri1,
  input  logic [15:0] rj1,
  input  logic [2:0]  func0,
  input  logic [2:0]  func1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        res_zero,
  output logic        res_err,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]  op_f_q, op_f_d;
  logic        owner_q, owner_d, last_q, last_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [15:0] res_q, res_d;
  logic        res_zero_q, res_zero_d, res_err_q, res_err_d;
  logic        win;
  logic [15:0] alu_y;
  logic        alu_z, alu_err;

  alu u_alu (
    .a   (op_a_q),
    .b   (op_b_q),
    .f   (op_f_q),
    .y   (alu_y),
    .z   (alu_z),
    .err (alu_err)
  );

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_f_d     = op_f_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    done0_d    = done0_q;
    done1_d    = done1_q;
    res_d      = res_q;
    res_zero_d = res_zero_q;
    res_err_d  = res_err_q;
    win        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // on a tie the client not served last wins
          win     = (req0 && req1) ? ~last_q : req1;
          op_a_d  = win ? ri1 : ri0;
          op_b_d  = win ? rj1 : rj0;
          op_f_d  = win ? func1 : func0;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d      = alu_y;
        res_zero_d = alu_err ? 1'b0 : alu_z;
        res_err_d  = alu_err;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = ~owner_q;
        done1_d    = owner_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_a_q     <= 16'h0000;
      op_b_q     <= 16'h0000;
      op_f_q     <= 3'b000;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      res_q      <= 16'h0000;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_f_q     <= op_f_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res      = res_q;
  assign res_zero = res_zero_q;
  assign res_err  = res_err_q;
  assign busy     = (state_q != S_IDLE);
endmodule
